sample_window_reader: RTL and testbench

Read-side controller for `sample_fifo`. It drains a window of `i_win_len` samples from the FIFO and replays that window `i_passes` times, using the FIFO's mark and rewind controls (`i_mark_read_rst` / `i_read_rst`). Samples go to a downstream valid/ready consumer, such as a filter or correlator engine. The block is the consumer end of the FIFO's pop/front/vld interface.

---
 rtl/sample_window_reader.sv | 194 +++++++++++++++++++
 tb/tb_sample_window_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_window_reader.sv
// Purpose: read-side controller for sample_fifo; drains a window of i_win_len samples and replays it
//          i_passes times using the FIFO mark/rewind pulses, feeding a valid/ready consumer.
// Latency: start -> MARK (1) -> first pop (2) -> first o_data_vld (4); one sample/cycle; one bubble per rewind.
// Backpressure: pops are credit-gated against a 2-entry output buffer; o_data holds while o_data_vld && !i_ready.
// Ports: clk/rst_n (async active-low); job control i_start/i_win_len/i_passes/i_abort -> o_busy/o_done;
//        FIFO side o_pop/i_front/i_vld/i_empty/o_mark_read_rst/o_read_rst; stream o_data/o_data_vld/i_ready.
// Option: define SWR_SAMPLE_TAG_EN to add o_last (final sample of a pass) and o_pass (0-based pass index).
module sample_window_reader #(
   parameter int DATA_W  = 16,
   parameter int WIN_MAX = 32,
   parameter int PASS_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_start,
   input  logic [$clog2(WIN_MAX+1)-1:0] i_win_len,
   input  logic [PASS_W-1:0]            i_passes,
   input  logic                         i_abort,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_pop,
   input  logic [DATA_W-1:0]            i_front,
   input  logic                         i_vld,
   input  logic                         i_empty,
   output logic                         o_mark_read_rst,
   output logic                         o_read_rst,
   output logic [DATA_W-1:0]            o_data,
   output logic                         o_data_vld,
`ifdef SWR_SAMPLE_TAG_EN
   output logic                         o_last,
   output logic [PASS_W-1:0]            o_pass,
`endif
   input  logic                         i_ready
);

   localparam int WL_W = $clog2(WIN_MAX+1);
`ifdef SWR_SAMPLE_TAG_EN
   localparam int ENT_W = DATA_W + 1 + PASS_W;
`else
   localparam int ENT_W = DATA_W;
`endif

   typedef enum logic [2:0] {S_IDLE, S_MARK, S_READ, S_REWIND, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [WL_W-1:0]   win_len, pop_cnt, win_clamp;
   logic [PASS_W-1:0] passes, pass_cnt;
   logic              inflight;
   logic [1:0]        buf_cnt;
   logic [ENT_W-1:0]  ent0, ent1, new_ent;
   logic [2:0]        occ;
   logic              accept, credit, last_pop, more_passes, abort_now, buf_wr;
`ifdef SWR_SAMPLE_TAG_EN
   logic              inflight_last;
   logic [PASS_W-1:0] inflight_pass;
`endif

   assign win_clamp   = (i_win_len > WL_W'(WIN_MAX)) ? WL_W'(WIN_MAX) : i_win_len;
   assign accept      = o_data_vld && i_ready;
   // Occupancy the buffer will need if nothing else arrives: entries held plus the sample in flight,
   // minus the one leaving this cycle. Never negative because accept implies buf_cnt >= 1.
   assign occ         = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, accept};
   assign credit      = occ < 3'd2;
   assign last_pop    = ({1'b0, pop_cnt} + 1'b1) == {1'b0, win_len};
   assign more_passes = ({1'b0, pass_cnt} + 1'b1) < {1'b0, passes};
   assign abort_now   = i_abort && (state != S_IDLE);
   // Only samples from our own live pops are kept; a pop issued in the abort cycle comes back to nothing.
   assign buf_wr      = i_vld && inflight;

`ifdef SWR_SAMPLE_TAG_EN
   assign new_ent = {inflight_pass, inflight_last, i_front};
   assign o_last  = ent0[DATA_W];
   assign o_pass  = ent0[DATA_W+1 +: PASS_W];
`else
   assign new_ent = i_front;
`endif

   assign o_data     = ent0[DATA_W-1:0];
   assign o_data_vld = (buf_cnt != 2'd0);
   assign o_busy     = (state != S_IDLE);

   always_comb begin
      state_nxt       = state;
      o_pop           = 1'b0;
      o_mark_read_rst = 1'b0;
      o_read_rst      = 1'b0;
      o_done          = 1'b0;
      case (state)
         S_IDLE:   if (i_start)
                      state_nxt = (win_clamp == '0 || i_passes == '0) ? S_DONE : S_MARK;
         S_MARK:   begin
                      o_mark_read_rst = 1'b1;
                      state_nxt       = S_READ;
                   end
         S_READ:   begin
                      o_pop = !i_empty && credit;
                      if (o_pop && last_pop)
                         state_nxt = more_passes ? S_REWIND : S_DRAIN;
                   end
         S_REWIND: begin
                      o_read_rst = 1'b1;
                      state_nxt  = S_READ;
                   end
         // Leave as soon as the final entry is being accepted so o_done follows it by one cycle.
         S_DRAIN:  if (!inflight && (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && accept)))
                      state_nxt = S_DONE;
         S_DONE:   begin
                      o_done    = 1'b1;
                      state_nxt = S_IDLE;
                   end
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_now) begin
         state_nxt = S_IDLE;
         o_done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         win_len  <= '0;
         passes   <= '0;
         pop_cnt  <= '0;
         pass_cnt <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= o_pop && !abort_now;
         case (state)
            S_IDLE:   if (i_start) begin
                         win_len <= win_clamp;
                         passes  <= i_passes;
                      end
            S_MARK:   begin
                         pop_cnt  <= '0;
                         pass_cnt <= '0;
                      end
            S_READ:   if (o_pop) begin
                         pop_cnt <= pop_cnt + 1'b1;
                         if (last_pop)
                            pass_cnt <= pass_cnt + 1'b1;
                      end
            S_REWIND: pop_cnt <= '0;
            default:  ;
         endcase
      end
   end

`ifdef SWR_SAMPLE_TAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_last <= 1'b0;
         inflight_pass <= '0;
      end else begin
         inflight_last <= last_pop;
         inflight_pass <= pass_cnt;
      end
   end
`endif

   // Two-entry output buffer; ent0 is always the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_cnt <= 2'd0;
         ent0    <= '0;
         ent1    <= '0;
      end else if (abort_now) begin
         buf_cnt <= 2'd0;
      end else begin
         case ({buf_wr, accept})
            2'b10: begin
                      if (buf_cnt == 2'd0) ent0 <= new_ent;
                      else                 ent1 <= new_ent;
                      buf_cnt <= buf_cnt + 2'd1;
                   end
            2'b01: begin
                      ent0    <= ent1;
                      buf_cnt <= buf_cnt - 2'd1;
                   end
            2'b11: begin
                      if (buf_cnt == 2'd1) begin
                         ent0 <= new_ent;
                      end else begin
                         ent0 <= ent1;
                         ent1 <= new_ent;
                      end
                   end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_window_reader.sv
module tb_sample_window_reader;
   localparam int DATA_W  = 16;
   localparam int WIN_MAX = 32;
   localparam int PASS_W  = 8;
   localparam int WL_W    = $clog2(WIN_MAX+1);
   localparam int R_ONE = 0, R_TOG = 1, R_RND = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
   logic [WL_W-1:0]   i_win_len = '0;
   logic [PASS_W-1:0] i_passes = '0;
   logic              o_busy, o_done, o_pop, o_mark_read_rst, o_read_rst, o_data_vld;
   logic [DATA_W-1:0] o_data;
   logic [DATA_W-1:0] i_front = '0;
   logic              i_vld = 1'b0;
   logic              i_empty;
`ifdef SWR_SAMPLE_TAG_EN
   logic              o_last;
   logic [PASS_W-1:0] o_pass;
`endif

   always #5 clk = ~clk;

   sample_window_reader #(.DATA_W(DATA_W), .WIN_MAX(WIN_MAX), .PASS_W(PASS_W)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_win_len(i_win_len), .i_passes(i_passes),
      .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_pop(o_pop), .i_front(i_front),
      .i_vld(i_vld), .i_empty(i_empty), .o_mark_read_rst(o_mark_read_rst), .o_read_rst(o_read_rst),
      .o_data(o_data), .o_data_vld(o_data_vld),
`ifdef SWR_SAMPLE_TAG_EN
      .o_last(o_last), .o_pass(o_pass),
`endif
      .i_ready(i_ready));

   // Environment: behavioural sample_fifo with mark/rewind. wr_ptr is advanced by the stimulus.
   logic [DATA_W-1:0] mem [0:1023];
   int   wr_ptr = 0, rd_ptr = 0, mark_ptr = 0;
   logic flush = 1'b0;
   assign i_empty = (rd_ptr >= wr_ptr);
   always @(posedge clk) begin
      i_vld <= o_pop;
      if (o_pop) begin
         i_front <= mem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
      if (o_mark_read_rst) mark_ptr <= rd_ptr;
      if (o_read_rst)      rd_ptr   <= mark_ptr;
      if (flush) begin
         rd_ptr   <= wr_ptr;
         mark_ptr <= wr_ptr;
      end
   end

   int total = 0, bad = 0;
   int n_mark, n_rr, n_pop, n_done, n_out, first_vld, done_cyc;
   logic [DATA_W-1:0] exp_q[$];
   logic              exp_last_q[$];
   int                exp_pass_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fifo_load(input int n_total, input int n_vis, input bit seq);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      for (int k = 0; k < n_total; k++)
         mem[wr_ptr + k] = seq ? DATA_W'(k) : DATA_W'($urandom);
      wr_ptr += n_vis;
   endtask

   // Reference: the window is the next eff samples at the FIFO read position, emitted np times in order.
   task automatic run_job(input int wl, input int np, input int rmode, input int late_c, input int late_n,
                          input int abort_c, input int rst_c);
      int eff, base, c;
      bit fin, hold;
      logic [DATA_W-1:0] held, e;
      eff = (wl > WIN_MAX) ? WIN_MAX : wl;
      @(negedge clk);
      base = rd_ptr;
      exp_q.delete(); exp_last_q.delete(); exp_pass_q.delete();
      if (eff > 0 && np > 0)
         for (int p = 0; p < np; p++)
            for (int i = 0; i < eff; i++) begin
               exp_q.push_back(mem[base + i]);
               exp_last_q.push_back(i == eff - 1);
               exp_pass_q.push_back(p);
            end
      n_mark = 0; n_rr = 0; n_pop = 0; n_done = 0; n_out = 0; first_vld = -1; done_cyc = -1;
      i_win_len = wl[WL_W-1:0]; i_passes = np[PASS_W-1:0]; i_start = 1'b1; i_ready = 1'b1;
      fin = 0; hold = 0; held = '0; c = 0;
      while (!fin) begin
         #1;
         if (c == rst_c) begin
            rst_n = 1'b0;
            #1;
            check("reset_mid_job", {o_busy, o_done, o_pop, o_mark_read_rst, o_read_rst, o_data_vld, o_data}, 64'd0);
            fin = 1;
         end else begin
            if (o_mark_read_rst) n_mark++;
            if (o_read_rst)      n_rr++;
            if (o_pop)           n_pop++;
            if (o_done) begin n_done++; done_cyc = c; end
            if (o_data_vld && first_vld < 0) first_vld = c;
            if (hold) check("hold_stable", {o_data_vld, o_data}, {1'b1, held});
            hold = o_data_vld && !i_ready;
            held = o_data;
            if (o_data_vld && i_ready) begin
               n_out++;
               if (exp_q.size() == 0) check("extra_sample", {1'b1, o_data}, 64'd0);
               else begin
                  e = exp_q.pop_front();
                  check("data", o_data, e);
`ifdef SWR_SAMPLE_TAG_EN
                  check("tag_last", o_last, exp_last_q[0]);
                  check("tag_pass", o_pass, exp_pass_q[0]);
`endif
                  void'(exp_last_q.pop_front());
                  void'(exp_pass_q.pop_front());
               end
            end
            if (abort_c >= 0 && c == abort_c + 1) begin
               check("abort_busy", o_busy, 0);
               check("abort_vld", o_data_vld, 0);
            end
            if (done_cyc >= 0 || (abort_c >= 0 && c == abort_c + 6) || c >= 600) fin = 1;
         end
         if (!fin) begin
            @(negedge clk);
            c++;
            i_start = 1'b0;
            i_abort = (c == abort_c);
            case (rmode)
               R_TOG:   i_ready = ((c / 2) % 2) == 0;
               R_RND:   i_ready = ($urandom_range(0, 3) != 0);
               default: i_ready = 1'b1;
            endcase
            if (c == late_c) wr_ptr += late_n;
         end
      end
      i_start = 1'b0; i_abort = 1'b0;
      if (rst_c >= 0) begin
         @(negedge clk); @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      int wl, np, eff;
      repeat (3) @(negedge clk);
      #1;
      check("reset_state", {o_busy, o_done, o_pop, o_mark_read_rst, o_read_rst, o_data_vld, o_data}, 64'd0);
      rst_n = 1'b1;

      // single pass, sequential data, full-rate consumer
      fifo_load(32, 32, 1);
      run_job(8, 1, R_ONE, -1, 0, -1, -1);
      check("p1_first_vld", first_vld, 4);
      check("p1_done_cyc", done_cyc, 12);
      check("p1_outputs", n_out, 8);
      check("p1_marks", n_mark, 1);
      check("p1_rewinds", n_rr, 0);
      check("p1_dones", n_done, 1);
      @(negedge clk); #1;
      check("p1_idle_after", o_busy, 0);

      // three passes, random data
      fifo_load(32, 32, 0);
      run_job(5, 3, R_ONE, -1, 0, -1, -1);
      check("p3_done_cyc", done_cyc, 21);
      check("p3_outputs", n_out, 15);
      check("p3_rewinds", n_rr, 2);
      check("p3_pops", n_pop, 15);
      check("p3_left", exp_q.size(), 0);

      // same with ready toggling every 2 cycles
      fifo_load(32, 32, 0);
      run_job(5, 3, R_TOG, -1, 0, -1, -1);
      check("tog_outputs", n_out, 15);
      check("tog_dones", n_done, 1);
      check("tog_left", exp_q.size(), 0);

      // FIFO runs dry mid-window, refilled at cycle 10
      fifo_load(6, 3, 1);
      run_job(6, 1, R_ONE, 10, 3, -1, -1);
      check("dry_outputs", n_out, 6);
      check("dry_done_cyc", done_cyc, 15);

      // degenerate jobs
      fifo_load(8, 8, 0);
      run_job(0, 3, R_ONE, -1, 0, -1, -1);
      check("zero_done_cyc", done_cyc, 1);
      check("zero_marks", n_mark, 0);
      check("zero_pops", n_pop, 0);
      run_job(5, 0, R_ONE, -1, 0, -1, -1);
      check("nopass_done_cyc", done_cyc, 1);
      check("nopass_pops", n_pop, 0);

      // window longer than WIN_MAX is clamped
      fifo_load(40, 40, 0);
      run_job(40, 1, R_ONE, -1, 0, -1, -1);
      check("clamp_outputs", n_out, 32);
      check("clamp_pops", n_pop, 32);
      check("clamp_done_cyc", done_cyc, 36);

      // random jobs with random backpressure
      for (int t = 0; t < 5; t++) begin
         wl  = $urandom_range(1, 32);
         np  = $urandom_range(1, 3);
         eff = wl;
         fifo_load(32, 32, 0);
         run_job(wl, np, R_RND, -1, 0, -1, -1);
         check("rnd_outputs", n_out, eff * np);
         check("rnd_rewinds", n_rr, np - 1);
         check("rnd_dones", n_done, 1);
         check("rnd_left", exp_q.size(), 0);
      end

      // abort during the second pass, then a normal job
      fifo_load(32, 32, 0);
      run_job(8, 4, R_ONE, -1, 0, 14, -1);
      check("abort_no_done", n_done, 0);
      fifo_load(32, 32, 0);
      run_job(4, 2, R_ONE, -1, 0, -1, -1);
      check("post_abort_done_cyc", done_cyc, 13);
      check("post_abort_outputs", n_out, 8);

      // reset mid-job, then a normal job
      fifo_load(32, 32, 0);
      run_job(8, 2, R_ONE, -1, 0, -1, 7);
      fifo_load(32, 32, 0);
      run_job(3, 1, R_ONE, -1, 0, -1, -1);
      check("post_rst_done_cyc", done_cyc, 7);
      check("post_rst_outputs", n_out, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
